// File: rtl/game_timer_pkg.sv
// Shared encodings and constants for the countdown game timer.
package game_timer_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: subtracts the incoming borrow, wrapping
// 0 -> max and passing the borrow on to the next more significant digit.
module bcd_down_digit
   import game_timer_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             borrow_in,
   input  logic [BCD_W-1:0] max,
   output logic [BCD_W-1:0] next_digit,
   output logic             borrow_out
);

   // wrap to max when borrowing from zero, otherwise subtract the borrow
   always_comb begin
      next_digit = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit != '0) begin
            next_digit = digit - 1'b1;
         end else begin
            next_digit = max;
            borrow_out = 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_timer.sv
// mm:ss BCD countdown timer driven by a sampled 1 Hz tick, with
// start / pause / restart control and a one-cycle time_up pulse.
//
// state | meaning
// IDLE  | preset shown, waiting for start
// RUN   | counting down one second per tick rise
// PAUSE | digits frozen, tick rises dropped
// DONE  | 00:00 reached, waiting for start
module game_timer
   import game_timer_pkg::*;
#(
   parameter int START_MIN = 1,
   parameter int START_SEC = 30
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             start,
   input  logic             pause,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             running,
   output logic             done,
   output logic             time_up
);

   localparam logic [4*BCD_W-1:0] PRESET = {BCD_W'(START_MIN / 10), BCD_W'(START_MIN % 10),
                                            BCD_W'(START_SEC / 10), BCD_W'(START_SEC % 10)};
   localparam bit PRESET_ZERO = (START_MIN == 0) && (START_SEC == 0);

   state_t             state, state_nxt;
   logic [4*BCD_W-1:0] digits, digits_nxt;
   logic               time_up_nxt;
   logic               tick_d;
   logic               tick_rise;

   logic [BCD_W-1:0]   so_dec, st_dec, mo_dec, mt_dec;
   logic               b_so, b_st, b_mo, underflow;
   logic [4*BCD_W-1:0] digits_dec;

   assign tick_rise = tick_in & ~tick_d;

   bcd_down_digit u_sec_ones (.digit(digits[3:0]),   .borrow_in(1'b1), .max(DIGIT_MAX),
                              .next_digit(so_dec), .borrow_out(b_so));
   bcd_down_digit u_sec_tens (.digit(digits[7:4]),   .borrow_in(b_so), .max(SEC_TENS_MAX),
                              .next_digit(st_dec), .borrow_out(b_st));
   bcd_down_digit u_min_ones (.digit(digits[11:8]),  .borrow_in(b_st), .max(DIGIT_MAX),
                              .next_digit(mo_dec), .borrow_out(b_mo));
   bcd_down_digit u_min_tens (.digit(digits[15:12]), .borrow_in(b_mo), .max(DIGIT_MAX),
                              .next_digit(mt_dec), .borrow_out(underflow));

   // a borrow out of the top digit means the value was 00:00; never apply it
   assign digits_dec = {mt_dec, mo_dec, st_dec, so_dec};

   // next state, next digits and time_up; start overrides everything else
   always_comb begin
      state_nxt   = state;
      digits_nxt  = digits;
      time_up_nxt = 1'b0;
      if (start) begin
         digits_nxt = PRESET;
         if (PRESET_ZERO) begin
            state_nxt   = DONE;
            time_up_nxt = 1'b1;
         end else begin
            state_nxt = RUN;
         end
      end else begin
         case (state)
            RUN: begin
               if (pause) begin
                  state_nxt = PAUSE;
               end else if (tick_rise && !underflow) begin
                  digits_nxt = digits_dec;
                  if (digits_dec == '0) begin
                     state_nxt   = DONE;
                     time_up_nxt = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (pause) state_nxt = RUN;
            end
            default: ;
         endcase
      end
   end

   // state, digit and edge-detect registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         digits  <= PRESET;
         time_up <= 1'b0;
         tick_d  <= 1'b0;
      end else begin
         state   <= state_nxt;
         digits  <= digits_nxt;
         time_up <= time_up_nxt;
         tick_d  <= tick_in;
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = digits;
   assign running = (state == RUN);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: default 01:30 preset, a 00:02 preset and a
// 00:00 preset instance share the same stimulus.
module tb_game_timer;

   logic clk = 1'b0;
   logic rst, tick_in, start, pause;

   logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so, c_mt, c_mo, c_st, c_so;
   logic       a_run, a_done, a_tu, b_run, b_done, b_tu, c_run, c_done, c_tu;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   game_timer dut_a (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
      .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
      .running(a_run), .done(a_done), .time_up(a_tu));

   game_timer #(.START_MIN(0), .START_SEC(2)) dut_b (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
      .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
      .running(b_run), .done(b_done), .time_up(b_tu));

   game_timer #(.START_MIN(0), .START_SEC(0)) dut_c (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
      .min_tens(c_mt), .min_ones(c_mo), .sec_tens(c_st), .sec_ones(c_so),
      .running(c_run), .done(c_done), .time_up(c_tu));

   wire [15:0] dig_a = {a_mt, a_mo, a_st, a_so};
   wire [15:0] dig_b = {b_mt, b_mo, b_st, b_so};
   wire [15:0] dig_c = {c_mt, c_mo, c_st, c_so};
   wire [2:0]  flg_a = {a_run, a_done, a_tu};
   wire [2:0]  flg_b = {b_run, b_done, b_tu};
   wire [2:0]  flg_c = {c_run, c_done, c_tu};

   typedef struct {
      logic        st;
      logic        pa;
      logic        tk;
      logic [15:0] dig;
      logic [2:0]  flg;
   } vec_t;

   vec_t tbl[20];

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic tick_up();
      tick_in = 1'b1;
      cyc();
   endtask

   task automatic tick_down();
      cyc();
      tick_in = 1'b0;
      cyc();
   endtask

   task automatic rise();
      tick_up();
      tick_down();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
   endtask

   initial begin
      // flags are {running, done, time_up}
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h0130, 3'b000};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0130, 3'b000};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0130, 3'b100};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0129, 3'b100};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0129, 3'b100};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0128, 3'b100};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0128, 3'b000};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0128, 3'b000};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0128, 3'b000};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0128, 3'b100};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0127, 3'b100};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0130, 3'b100};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h0130, 3'b000};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h0130, 3'b100};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 16'h0130, 3'b100};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0130, 3'b100};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 16'h0129, 3'b100};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0129, 3'b000};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 16'h0130, 3'b100};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 16'h0130, 3'b100};

      rst = 1'b1; tick_in = 1'b0; start = 1'b0; pause = 1'b0;
      repeat (3) cyc();
      chk("reset_digits", dig_a, 16'h0130);
      chk("reset_flags", {13'd0, flg_a}, 16'h0000);
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 5; i++) begin
         rise();
         chk("idle_tick_ignored", dig_a, 16'h0130);
      end
      chk("idle_flags", {13'd0, flg_a}, 16'h0000);

      for (int i = 0; i < 20; i++) begin
         start = tbl[i].st; pause = tbl[i].pa; tick_in = tbl[i].tk;
         cyc();
         start = 1'b0; pause = 1'b0;
         chk($sformatf("vec%0d_digits", i), dig_a, tbl[i].dig);
         chk($sformatf("vec%0d_flags", i), {13'd0, flg_a}, {13'd0, tbl[i].flg});
      end

      // 31 rises from 01:30, each visible one clock after the sampled rise
      pulse_start();
      chk("start_digits", dig_a, 16'h0130);
      for (int i = 1; i <= 31; i++) begin
         tick_up();
         chk($sformatf("count_%0d", i), dig_a, to_bcd(90 - i));
         tick_down();
      end
      chk("count_end", dig_a, 16'h0059);

      // pause at 01:10: ticks dropped, not deferred
      pulse_start();
      repeat (20) rise();
      chk("at_0110", dig_a, 16'h0110);
      pulse_pause();
      chk("paused_flags", {13'd0, flg_a}, 16'h0000);
      repeat (3) rise();
      chk("paused_hold", dig_a, 16'h0110);
      pulse_pause();
      chk("resumed_flags", {13'd0, flg_a}, 16'h0004);
      tick_up();
      chk("resume_tick", dig_a, 16'h0109);
      tick_down();

      // start+pause together and start+tick together at 00:45
      repeat (24) rise();
      chk("at_0045", dig_a, 16'h0045);
      start = 1'b1; pause = 1'b1;
      cyc();
      start = 1'b0; pause = 1'b0;
      chk("start_pause_digits", dig_a, 16'h0130);
      chk("start_pause_flags", {13'd0, flg_a}, 16'h0004);
      tick_in = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_tick_digits", dig_a, 16'h0130);
      tick_down();
      chk("start_tick_after", dig_a, 16'h0130);

      // reset mid-count at 00:17 with tick held high through release
      repeat (73) rise();
      chk("at_0017", dig_a, 16'h0017);
      rst = 1'b1; tick_in = 1'b1;
      cyc();
      chk("midreset_digits", dig_a, 16'h0130);
      chk("midreset_flags", {13'd0, flg_a}, 16'h0000);
      rst = 1'b0;
      repeat (2) cyc();
      pulse_start();
      chk("post_reset_start", dig_a, 16'h0130);
      repeat (3) cyc();
      chk("held_tick_no_dec", dig_a, 16'h0130);
      tick_in = 1'b0;
      cyc();
      tick_up();
      chk("first_real_rise", dig_a, 16'h0129);
      tick_down();

      // 00:02 and 00:00 presets
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("b_reset", dig_b, 16'h0002);
      chk("c_reset_flags", {13'd0, flg_c}, 16'h0000);
      pulse_start();
      chk("b_start", dig_b, 16'h0002);
      chk("c_zero_start_digits", dig_c, 16'h0000);
      chk("c_zero_start_flags", {13'd0, flg_c}, 16'h0003);
      cyc();
      chk("c_zero_after", {13'd0, flg_c}, 16'h0002);
      tick_up();
      chk("b_first", dig_b, 16'h0001);
      tick_down();
      tick_up();
      chk("b_zero_digits", dig_b, 16'h0000);
      chk("b_zero_flags", {13'd0, flg_b}, 16'h0003);
      cyc();
      chk("b_tu_one_cycle", {13'd0, flg_b}, 16'h0002);
      tick_in = 1'b0;
      cyc();
      rise();
      chk("b_done_hold", dig_b, 16'h0000);
      pulse_pause();
      chk("b_done_pause_ign", {13'd0, flg_b}, 16'h0002);
      pulse_start();
      chk("b_restart_digits", dig_b, 16'h0002);
      chk("b_restart_flags", {13'd0, flg_b}, 16'h0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
